// File: rtl/keypad_pkg.sv
// Purpose : shared types, row codes and default timing for the keypad scanner.
// Latency : n/a (declarations and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   state_t                 scanner FSM states
//   ROW_CODE_0..3           active-low one-hot row drive patterns
//   DEFAULT_SCAN_CYCLES     per-row dwell, in clk cycles
//   DEFAULT_DEBOUNCE_CYCLES stable cycles needed to accept a press or release
//   row_code()              row index -> active-low one-hot drive pattern
//   lowest_low()            isolate the lowest-index low bit of a column word
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] ROW_CODE_0 = 4'b1110;
    localparam logic [3:0] ROW_CODE_1 = 4'b1101;
    localparam logic [3:0] ROW_CODE_2 = 4'b1011;
    localparam logic [3:0] ROW_CODE_3 = 4'b0111;

    localparam int unsigned DEFAULT_SCAN_CYCLES     = 50000;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

    // Row index to drive pattern. Exactly one bit is low for every index.
    function automatic logic [3:0] row_code(input logic [1:0] idx);
        logic [3:0] code;
        case (idx)
            2'd0:    code = ROW_CODE_0;
            2'd1:    code = ROW_CODE_1;
            2'd2:    code = ROW_CODE_2;
            default: code = ROW_CODE_3;
        endcase
        return code;
    endfunction

    // Keep only the lowest-index low bit of v; every other bit is forced high.
    // An all-ones input returns all ones.
    function automatic logic [3:0] lowest_low(input logic [3:0] v);
        logic [3:0] res;
        res = 4'b1111;
        if (!v[0]) begin
            res = 4'b1110;
        end else if (!v[1]) begin
            res = 4'b1101;
        end else if (!v[2]) begin
            res = 4'b1011;
        end else if (!v[3]) begin
            res = 4'b0111;
        end
        return res;
    endfunction

endpackage

// File: rtl/sync2.sv
// Purpose : two-flop synchronizer for a bus of independent asynchronous levels.
// Latency : 2 core_clk cycles from d to q.
// Backpressure: none; samples every cycle.
//
// Ports:
//   core_clk  destination clock
//   arst_n    asynchronous active-low reset, forces both stages to all ones
//   d         asynchronous input bits (no relationship assumed between bits)
//   q         synchronized output
module sync2 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // First stage may go metastable; only the second stage is consumed.
    logic [WIDTH-1:0] meta;

    // All-ones reset matches the idle level of pulled-up keypad columns, so
    // nothing downstream sees a phantom press while coming out of reset.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Purpose : 4x4 matrix keypad scanner with press/release debounce and a latched key code.
// Latency : col -> scol 2 cycles; key_valid one cycle after DEBOUNCE_CYCLES stable-low cycles.
// Backpressure: none; key_valid is a single-cycle pulse with no ready.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset      asynchronous active-low reset
//   col[3:0]   raw column lines, active low, asynchronous to clk
//   row[3:0]   row drive, active-low one-hot
//   key_row    row code of the last accepted key (active-low one-hot), all ones until first press
//   key_col    column code of the last accepted key (active-low one-hot), all ones until first press
//   key_valid  one-cycle pulse when a new press is accepted
//
// key_row/key_col are plain registered one-hot codes so they can be wired
// straight into keypad_decoder's row/col inputs by the parent.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES     = DEFAULT_SCAN_CYCLES,     // >= 3
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES  // >= 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic       key_valid
);

    // Each counter only has to reach PARAM-1, so $clog2(PARAM) bits suffice.
    localparam int unsigned DW = $clog2(SCAN_CYCLES);
    localparam int unsigned BW = $clog2(DEBOUNCE_CYCLES);

    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
    localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Column synchronizer
    // ------------------------------------------------------------------
    logic [3:0] scol;

    sync2 #(
        .WIDTH (4)
    ) u_col_sync (
        .core_clk (clk),
        .arst_n   (reset),
        .d        (col),
        .q        (scol)
    );

    // ------------------------------------------------------------------
    // Scanner state
    // ------------------------------------------------------------------
    state_t          state;
    logic [1:0]      row_idx;
    logic [DW-1:0]   dwell;     // cycles spent on the current row while scanning
    logic [BW-1:0]   db_cnt;    // consecutive stable cycles in DEBOUNCE/RELEASE
    logic [3:0]      cand;      // active-low one-hot column being tracked

    // Only the tracked column matters once a candidate exists; every other
    // column is masked high, which is what makes second presses invisible
    // until the first key has fully released.
    logic cand_low;
    assign cand_low = ((scol | cand) != 4'b1111);

    logic [1:0] row_idx_next;
    assign row_idx_next = row_idx + 2'd1;   // 3 wraps to 0 naturally

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SCAN;
            row_idx   <= 2'd0;
            row       <= ROW_CODE_0;
            dwell     <= '0;
            db_cnt    <= '0;
            cand      <= 4'b1111;
            key_row   <= 4'b1111;
            key_col   <= 4'b1111;
            key_valid <= 1'b0;
        end else begin
            // Pulse by default; only the DEBOUNCE->HELD edge raises it.
            key_valid <= 1'b0;

            case (state)
                // Columns are only looked at on the final dwell cycle so
                // the row drive and the synchronizer have settled.
                SCAN: begin
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (scol == 4'b1111) begin
                            row_idx <= row_idx_next;
                            row     <= row_code(row_idx_next);
                        end else begin
                            cand   <= lowest_low(scol);
                            db_cnt <= '0;
                            state  <= DEBOUNCE;
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end

                // Row stays frozen. Any high reading on the candidate is
                // treated as bounce and scanning resumes on the same row
                // with a fresh dwell.
                DEBOUNCE: begin
                    if (!cand_low) begin
                        dwell <= '0;
                        state <= SCAN;
                    end else if (db_cnt == DB_LAST) begin
                        key_row   <= row;
                        key_col   <= cand;
                        key_valid <= 1'b1;
                        state     <= HELD;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end

                HELD: begin
                    if (!cand_low) begin
                        db_cnt <= '0;
                        state  <= RELEASE;
                    end
                end

                // A release must be as stable as a press; a low glitch
                // just drops back to HELD without re-announcing the key.
                RELEASE: begin
                    if (cand_low) begin
                        state <= HELD;
                    end else if (db_cnt == DB_LAST) begin
                        dwell   <= '0;
                        row_idx <= row_idx_next;
                        row     <= row_code(row_idx_next);
                        state   <= SCAN;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= SCAN;
                end
            endcase
        end
    end

endmodule
